inst_scroller: RTL and testbench
================================

Name: inst_scroller

Overview:
- Parametrised successor to the fixed-text instruction generators.
- Scrolls a caller-supplied message of up to MAX_LEN character codes, one per sec_clock tick, into a WIN_CHARS-wide display window.
- The message is followed by a programmable blank gap, then the block either finishes with a done pulse or loops.
- Sits between the ATM menu FSM (source of start, abort and message) and the display character decoder (consumer of instruction).

Parameters:
- CHAR_W, 5, bits per character code; code 0 = blank.
- WIN_CHARS, 8, characters visible in the window.
- MAX_LEN, 16, maximum message length in characters.
- GAP, 7, blank characters shifted in after the message; 0 allowed (no gap).

Ports:
- sec_clock  in  1  scroll tick clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a scroll; sampled only in IDLE.
- abort  in  1  stop the current scroll immediately.
- loop_en  in  1  repeat the message after the gap; sampled at end of each gap.
- msg_data  in  MAX_LEN*CHAR_W  char i is msg_data[i*CHAR_W +: CHAR_W].
- msg_len  in  $clog2(MAX_LEN+1)  number of valid characters.
- instruction  out  WIN_CHARS*CHAR_W  display window; newest char in the LSBs.
- busy  out  1  high while in SHIFT_MSG or SHIFT_GAP.
- done  out  1  one-cycle pulse at the end of a non-looping scroll.

Behaviour:
- Reset (rst=0, async): state=IDLE, instruction=0, busy=0, done=0, char index=0, gap counter=0, latched message and length=0.
- Every shift is {instruction[WIN_CHARS*CHAR_W-1-CHAR_W:0], new_char}; the oldest char falls off the MSBs.
- IDLE:
  - Accept on start=1 && abort=0 && msg_len!=0.
  - At the accept edge: latch msg_data, latch len=min(msg_len, MAX_LEN), instruction<=0, index<=0, busy<=1, go to SHIFT_MSG.
  - start with msg_len=0 is ignored; the block stays IDLE.
  - While IDLE, instruction holds its last value.
- SHIFT_MSG:
  - Each edge shifts in latched char[index] and increments index.
  - The edge that shifts char[len-1] goes to SHIFT_GAP, or to END_CHECK logic directly if GAP=0.
- SHIFT_GAP:
  - Each edge shifts in 0 and increments the gap counter.
  - The edge that shifts the GAP-th blank performs the end check.
- End check, done on the same edge as the last shift:
  - loop_en=1: index<=0, gap counter<=0, stay busy, go to SHIFT_MSG. The next edge shifts char[0] with no extra bubble.
  - loop_en=0: state<=IDLE, busy<=0, done<=1.
- done deasserts on the following edge. It never asserts on abort or reset.
- Latency: accept at edge k; chars at edges k+1..k+len; blanks at edges k+len+1..k+len+GAP; done high during the cycle after edge k+len+GAP.
- abort=1 at any edge while busy: state<=IDLE, instruction<=0, busy<=0, done<=0. abort has priority over start and over the end check.
- start while busy is ignored.
- msg_data, msg_len and loop_en changing mid-scroll do not affect the latched message. loop_en is sampled only at the end check.
- Reset mid-scroll aborts asynchronously to the reset values.
- Counters are sized for MAX_LEN and GAP and never wrap within a pass.

Test Plan:
- CHAR_W=5, WIN_CHARS=8, GAP=7. Message {9,14,16,21,20}, len=5, loop_en=0, start pulsed. Required: instruction=0 at the accept edge; 40'h00009742B4 after 5 shifts; 40'hA000000000 after the 7th blank; done high for exactly 1 cycle; busy low the same cycle.
- Same message with loop_en=1. Required: no done pulse; on the edge after the last blank the LSB char = 9 (40'h0000000009 visible after the first pass's gap shifts); the pattern repeats with a period of 12 edges.
- Assert abort on the 3rd message shift. Required: next edge instruction=0, busy=0, done never asserts; a new start is accepted on the following edge.
- start with msg_len=0 → stays IDLE, busy=0. msg_len=20 with MAX_LEN=16 → exactly 16 chars shifted, then the gap.
- GAP=0, len=3, loop_en=0. Required: done is registered on the same edge as the 3rd char; while looping, char[0] follows char[2] directly.
- rst=0 asserted asynchronously mid-gap, between clock edges. Required: outputs go to 0 immediately; after release, start is accepted normally.

Source files
------------

// File: rtl/inst_scroller.sv
// Scrolls a latched message of up to MAX_LEN character codes into a WIN_CHARS-wide
// window, one character per sec_clock tick, followed by GAP blanks, then finishes or loops.
module inst_scroller #(
  parameter int CHAR_W    = 5,
  parameter int WIN_CHARS = 8,
  parameter int MAX_LEN   = 16,
  parameter int GAP       = 7
) (
  input  logic                          sec_clock,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          loop_en,
  input  logic [MAX_LEN*CHAR_W-1:0]     msg_data,
  input  logic [$clog2(MAX_LEN+1)-1:0]  msg_len,
  output logic [WIN_CHARS*CHAR_W-1:0]   instruction,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state_dbg
);

  localparam int LW       = $clog2(MAX_LEN + 1);
  localparam int GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int WW       = WIN_CHARS * CHAR_W;
  localparam int MW       = MAX_LEN * CHAR_W;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_MSG = 2'd1,
    SHIFT_GAP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WW-1:0]       instr_q, instr_d;
  logic [LW-1:0]       idx_q, idx_d;
  logic [LW-1:0]       len_q, len_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [MW-1:0]       msg_q, msg_d;
  logic                done_q, done_d;
  logic [CHAR_W-1:0]   cur_char;
  logic                pass_end;

  always_ff @(posedge sec_clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      msg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      msg_q   <= msg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    idx_d    = idx_q;
    len_d    = len_q;
    gap_d    = gap_q;
    msg_d    = msg_q;
    done_d   = 1'b0;
    pass_end = 1'b0;
    cur_char = msg_q[idx_q*CHAR_W +: CHAR_W];

    case (state_q)
      IDLE: begin
        if (start && !abort && msg_len != '0) begin
          msg_d   = msg_data;
          len_d   = (msg_len > MAX_LEN_L) ? MAX_LEN_L : msg_len;
          instr_d = '0;
          idx_d   = '0;
          gap_d   = '0;
          state_d = SHIFT_MSG;
        end
      end
      SHIFT_MSG: begin
        if (abort) begin
          state_d = IDLE;
          instr_d = '0;
        end else begin
          instr_d = {instr_q[WW-CHAR_W-1:0], cur_char};
          idx_d   = idx_q + LW'(1);
          if (idx_q == len_q - LW'(1)) begin
            if (GAP == 0) begin
              pass_end = 1'b1;
            end else begin
              gap_d   = '0;
              state_d = SHIFT_GAP;
            end
          end
        end
      end
      SHIFT_GAP: begin
        if (abort) begin
          state_d = IDLE;
          instr_d = '0;
        end else begin
          instr_d = {instr_q[WW-CHAR_W-1:0], {CHAR_W{1'b0}}};
          gap_d   = gap_q + GW'(1);
          if (gap_q == GW'(GAP_LAST)) pass_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The end check shares the edge of the last shift so looping adds no bubble.
    if (pass_end) begin
      if (loop_en) begin
        idx_d   = '0;
        gap_d   = '0;
        state_d = SHIFT_MSG;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  assign instruction = instr_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_inst_scroller.sv
// Drives two scrollers (GAP=7 and GAP=0) with identical stimulus and compares each
// against a stream-level model: the window is the last WIN_CHARS characters fed in.
module tb_inst_scroller;

  localparam int CW = 5;
  localparam int WC = 8;
  localparam int ML = 16;
  localparam int WW = WC * CW;
  localparam int LW = $clog2(ML + 1);

  logic              sec_clock;
  logic              rst;
  logic              start;
  logic              abort;
  logic              loop_en;
  logic [ML*CW-1:0]  msg_data;
  logic [LW-1:0]     msg_len;
  logic [WW-1:0]     instr0, instr1;
  logic              busy0, busy1, done0, done1;
  logic [1:0]        st0, st1;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model state, index 0 = GAP 7 instance, index 1 = GAP 0 instance
  int           gap_of [2] = '{7, 0};
  bit           m_active [2];
  logic [WW-1:0] m_win [2];
  int           m_pos [2];
  int           m_len [2];
  logic [ML*CW-1:0] m_msg [2];
  bit           m_done [2];

  inst_scroller #(.CHAR_W(CW), .WIN_CHARS(WC), .MAX_LEN(ML), .GAP(7)) dut0 (
    .sec_clock(sec_clock), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
    .msg_data(msg_data), .msg_len(msg_len), .instruction(instr0), .busy(busy0),
    .done(done0), .state_dbg(st0)
  );

  inst_scroller #(.CHAR_W(CW), .WIN_CHARS(WC), .MAX_LEN(ML), .GAP(0)) dut1 (
    .sec_clock(sec_clock), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
    .msg_data(msg_data), .msg_len(msg_len), .instruction(instr1), .busy(busy1),
    .done(done1), .state_dbg(st1)
  );

  initial begin
    sec_clock = 1'b0;
    forever #5 sec_clock = ~sec_clock;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_active[id] = 0;
      m_win[id]    = '0;
      m_pos[id]    = 0;
      m_len[id]    = 0;
      m_done[id]   = 0;
    end
  endtask

  // One scroll pass is the message characters followed by the gap blanks.
  task automatic model_step(input int id);
    logic [CW-1:0] c;
    m_done[id] = 0;
    if (!m_active[id]) begin
      if (start && !abort && msg_len != 0) begin
        m_msg[id]    = msg_data;
        m_len[id]    = (int'(msg_len) > ML) ? ML : int'(msg_len);
        m_pos[id]    = 0;
        m_win[id]    = '0;
        m_active[id] = 1;
      end
    end else if (abort) begin
      m_active[id] = 0;
      m_win[id]    = '0;
    end else begin
      c = (m_pos[id] < m_len[id]) ? CW'(m_msg[id] >> (CW * m_pos[id])) : '0;
      m_win[id] = (m_win[id] << CW) | WW'(c);
      m_pos[id]++;
      if (m_pos[id] == m_len[id] + gap_of[id]) begin
        if (loop_en) m_pos[id] = 0;
        else begin
          m_active[id] = 0;
          m_done[id]   = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("instr_g7", 64'(instr0), 64'(m_win[0]));
    chk("busy_g7",  64'(busy0),  64'(m_active[0]));
    chk("done_g7",  64'(done0),  64'(m_done[0]));
    chk("instr_g0", 64'(instr1), 64'(m_win[1]));
    chk("busy_g0",  64'(busy1),  64'(m_active[1]));
    chk("done_g0",  64'(done1),  64'(m_done[1]));
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge sec_clock);
    #1;
    check_all();
  endtask

  task automatic load_msg5();
    int m1 [5] = '{9, 14, 16, 21, 20};
    msg_data = '0;
    for (int i = 0; i < 5; i++) msg_data[i*CW +: CW] = CW'(m1[i]);
    msg_len = LW'(5);
  endtask

  logic [WW-1:0] snap;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    msg_data = '0; msg_len = '0;
    model_reset();
    #1;
    check_all();
    @(posedge sec_clock);
    #1 rst = 1'b1;

    // Single non-looping pass
    load_msg5();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("win_after_msg", 64'(instr0), 64'h00009742B4);
    repeat (7) tick();
    chk("win_after_gap", 64'(instr0), 64'hA000000000);
    chk("done_pulse", 64'(done0), 64'd1);
    tick();

    // Looping pass: char[0] follows the last blank directly, period 12
    loop_en = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    chk("loop_restart", 64'(instr0), 64'h0000000009);
    snap = instr0;
    repeat (12) tick();
    chk("loop_period", 64'(instr0), 64'(snap));
    abort = 1'b1;
    tick();
    abort   = 1'b0;
    loop_en = 1'b0;
    tick();

    // Abort on the third message shift, then immediate restart
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    chk("abort_clear", 64'(instr0), 64'd0);
    abort = 1'b0;
    start = 1'b1;
    tick();
    chk("reaccept", 64'(busy0), 64'd1);
    start = 1'b0;
    repeat (14) tick();

    // Zero length is ignored; oversize length clamps to MAX_LEN
    msg_len = '0;
    start   = 1'b1;
    tick();
    chk("len0_idle", 64'(busy0), 64'd0);
    msg_data = {$urandom, $urandom, $urandom};
    msg_len  = LW'(20);
    tick();
    start = 1'b0;
    repeat (24) tick();

    // Asynchronous reset mid-gap
    load_msg5();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge sec_clock);
    #1 rst = 1'b1;
    start = 1'b1;
    tick();
    chk("post_reset_accept", 64'(busy0), 64'd1);
    start = 1'b0;

    // Randomized traffic, inputs including mid-scroll changes
    for (int n = 0; n < 600; n++) begin
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 29) == 0);
      loop_en  = ($urandom_range(0, 2) == 0);
      msg_len  = LW'($urandom_range(0, 20));
      msg_data = {$urandom, $urandom, $urandom};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
